// File: rtl/noise_event_sequencer.sv
// Shell/explosion noise sequencer: turns CPU sound-latch request edges into timed
// enable windows with per-channel hold-off and explosion-over-shell arbitration.
module noise_event_sequencer #(
  parameter int CNT_W          = 12,
  parameter int SHELL_ON_TICKS = 250,
  parameter int EXPLO_ON_TICKS = 250,
  parameter int HOLDOFF_TICKS  = 16,
  parameter int EXPLO_PREEMPT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_12KHz_en,
  input  logic       sound_enable,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic       shell_busy,
  output logic       explo_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } ch_state_e;

  typedef struct packed {
    ch_state_e        st;
    logic [CNT_W-1:0] cnt;
  } ch_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHELL_LOAD = (SHELL_ON_TICKS == 0) ? CNT_W'(1) : CNT_W'(SHELL_ON_TICKS);
  localparam logic [CNT_W-1:0] EXPLO_LOAD = (EXPLO_ON_TICKS == 0) ? CNT_W'(1) : CNT_W'(EXPLO_ON_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_TICKS);
  localparam logic             HOLD_NONE  = (HOLDOFF_TICKS == 0);
  localparam logic             PREEMPT_EN = (EXPLO_PREEMPT != 0);

  // Leaving ON: either a hold-off window or straight back to IDLE when none is configured.
  function automatic ch_t end_of_on();
    ch_t r;
    if (HOLD_NONE) begin
      r.st  = ST_IDLE;
      r.cnt = CNT_ZERO;
    end else begin
      r.st  = ST_HOLD;
      r.cnt = HOLD_LOAD;
    end
    return r;
  endfunction

  // One channel step; an accepted request has priority over a tick on the same clk.
  function automatic ch_t step_channel(ch_t cur, logic acc, logic tick, logic [CNT_W-1:0] on_load);
    ch_t r;
    r = cur;
    case (cur.st)
      ST_IDLE: begin
        if (acc) begin
          r.st  = ST_ON;
          r.cnt = on_load;
        end else begin
          r = cur;
        end
      end
      ST_ON: begin
        if (acc) begin
          r.cnt = on_load;
        end else if (tick) begin
          if (cur.cnt <= CNT_ONE) r = end_of_on();
          else r.cnt = cur.cnt - CNT_ONE;
        end else begin
          r = cur;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (cur.cnt <= CNT_ONE) begin
            r.st  = ST_IDLE;
            r.cnt = CNT_ZERO;
          end else begin
            r.cnt = cur.cnt - CNT_ONE;
          end
        end else begin
          r = cur;
        end
      end
      default: begin
        r.st  = ST_IDLE;
        r.cnt = CNT_ZERO;
      end
    endcase
    return r;
  endfunction

  ch_t        shell_q, shell_d, explo_q, explo_d;
  logic [1:0] prev_req_q, prev_req_d;
  logic       shell_ls_q, shell_ls_d, explo_ls_q, explo_ls_d;
  logic       shell_en_q, shell_en_d, explo_en_q, explo_en_d;
  logic       shell_busy_q, shell_busy_d, explo_busy_q, explo_busy_d;

  logic shell_req, explo_req, shell_acc, explo_acc, preempt_shell;

  // Rising-edge request detection against the previous write and channel arbitration.
  always_comb begin
    prev_req_d    = prev_req_q;
    explo_req     = cpu_wr & cpu_data[2] & ~prev_req_q[0] & sound_enable;
    shell_req     = cpu_wr & cpu_data[3] & ~prev_req_q[1] & sound_enable;
    explo_acc     = explo_req & (explo_q.st != ST_HOLD);
    shell_acc     = shell_req & (shell_q.st != ST_HOLD) & ~(PREEMPT_EN & explo_acc);
    preempt_shell = PREEMPT_EN & explo_acc & (shell_q.st == ST_ON);
    if (cpu_wr) begin
      prev_req_d = {cpu_data[3], cpu_data[2]};
    end else begin
      prev_req_d = prev_req_q;
    end
  end

  // Channel next state, loud/soft latching and registered output values.
  always_comb begin
    shell_d    = shell_q;
    explo_d    = explo_q;
    shell_ls_d = shell_ls_q;
    explo_ls_d = explo_ls_q;
    if (!sound_enable) begin
      shell_d.st  = ST_IDLE;
      shell_d.cnt = CNT_ZERO;
      explo_d.st  = ST_IDLE;
      explo_d.cnt = CNT_ZERO;
    end else begin
      explo_d = step_channel(explo_q, explo_acc, clk_12KHz_en, EXPLO_LOAD);
      if (preempt_shell) begin
        shell_d = end_of_on();
      end else begin
        shell_d = step_channel(shell_q, shell_acc, clk_12KHz_en, SHELL_LOAD);
      end
    end
    if (explo_acc) begin
      explo_ls_d = cpu_data[0];
    end else begin
      explo_ls_d = explo_ls_q;
    end
    if (shell_acc) begin
      shell_ls_d = cpu_data[1];
    end else begin
      shell_ls_d = shell_ls_q;
    end
    shell_en_d   = (shell_d.st == ST_ON);
    explo_en_d   = (explo_d.st == ST_ON);
    shell_busy_d = (shell_d.st != ST_IDLE);
    explo_busy_d = (explo_d.st != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shell_q.st   <= ST_IDLE;
      shell_q.cnt  <= CNT_ZERO;
      explo_q.st   <= ST_IDLE;
      explo_q.cnt  <= CNT_ZERO;
      prev_req_q   <= 2'b00;
      shell_ls_q   <= 1'b0;
      explo_ls_q   <= 1'b0;
      shell_en_q   <= 1'b0;
      explo_en_q   <= 1'b0;
      shell_busy_q <= 1'b0;
      explo_busy_q <= 1'b0;
    end else begin
      shell_q      <= shell_d;
      explo_q      <= explo_d;
      prev_req_q   <= prev_req_d;
      shell_ls_q   <= shell_ls_d;
      explo_ls_q   <= explo_ls_d;
      shell_en_q   <= shell_en_d;
      explo_en_q   <= explo_en_d;
      shell_busy_q <= shell_busy_d;
      explo_busy_q <= explo_busy_d;
    end
  end

  assign shell_en   = shell_en_q;
  assign shell_ls   = shell_ls_q;
  assign explo_en   = explo_en_q;
  assign explo_ls   = explo_ls_q;
  assign shell_busy = shell_busy_q;
  assign explo_busy = explo_busy_q;

endmodule

// File: tb/tb_noise_event_sequencer.sv
// Bench for noise_event_sequencer: tick-count model checked every cycle, plus
// directed scenarios with hand-computed window lengths.
module tb_noise_event_sequencer;
  localparam int ON_T   = 250;
  localparam int HOLD_T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, tick = 1'b0, se = 1'b1, wr = 1'b0;
  logic [7:0] data = 8'h00;
  logic       shell_en, shell_ls, explo_en, explo_ls, shell_busy, explo_busy;

  noise_event_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_12KHz_en(tick), .sound_enable(se),
    .cpu_wr(wr), .cpu_data(data),
    .shell_en(shell_en), .shell_ls(shell_ls), .explo_en(explo_en),
    .explo_ls(explo_ls), .shell_busy(shell_busy), .explo_busy(explo_busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int tick_mode = 0, phase = 0;
  int s_on_cnt = 0, s_hold_cnt = 0, e_on_cnt = 0;
  bit started = 0;

  // Model: remaining ON ticks and remaining hold-off ticks per channel.
  int   ms_on = 0, ms_hold = 0, me_on = 0, me_hold = 0;
  logic ms_ls = 1'b0, me_ls = 1'b0, mp_s = 1'b0, mp_e = 1'b0;

  task automatic adv(inout int on, inout int hold, inout logic ls, input bit acc, input logic nls);
    if (acc) begin
      on = ON_T; ls = nls;
    end else if (tick) begin
      if (on > 0) begin
        on--;
        if (on == 0) hold = HOLD_T;
      end else if (hold > 0) begin
        hold--;
      end
    end
  endtask

  always @(posedge clk) begin
    bit ef, sf, eacc, sacc, s_was_on;
    started = 1;
    if (tick && shell_en) s_on_cnt++;
    if (tick && shell_busy && !shell_en) s_hold_cnt++;
    if (tick && explo_en) e_on_cnt++;
    if (!rst_n) begin
      ms_on = 0; ms_hold = 0; me_on = 0; me_hold = 0;
      ms_ls = 1'b0; me_ls = 1'b0; mp_s = 1'b0; mp_e = 1'b0;
    end else begin
      ef = wr && data[2] && !mp_e;
      sf = wr && data[3] && !mp_s;
      if (wr) begin mp_e = data[2]; mp_s = data[3]; end
      if (!se) begin
        ms_on = 0; ms_hold = 0; me_on = 0; me_hold = 0;
      end else begin
        eacc = ef && (me_hold == 0);
        sacc = sf && (ms_hold == 0) && !eacc;
        s_was_on = (ms_on > 0);
        adv(me_on, me_hold, me_ls, eacc, data[0]);
        adv(ms_on, ms_hold, ms_ls, sacc, data[1]);
        if (eacc && s_was_on) begin ms_on = 0; ms_hold = HOLD_T; end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [5:0] act, exp;
    if (started) begin
      act = {shell_en, shell_ls, shell_busy, explo_en, explo_ls, explo_busy};
      exp = {ms_on > 0, ms_ls, (ms_on > 0) || (ms_hold > 0),
             me_on > 0, me_ls, (me_on > 0) || (me_hold > 0)};
      total++;
      if (act !== exp) begin
        bad++;
        if (bad < 40) $display("FAIL model t=%0t actual=%b expected=%b", $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d);
    wr = w; data = d;
    if (tick_mode == 0) tick = (phase % 4 == 3);
    else tick = ($urandom_range(0, 1) == 1);
    phase++;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  function automatic bit cond(input int kind, input int target);
    case (kind)
      0: return s_on_cnt >= target;
      1: return e_on_cnt >= target;
      2: return !shell_busy;
      3: return !explo_busy;
      4: return shell_busy && !shell_en;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_until(input int kind, input int target, input int budget, input string name);
    int n = 0;
    while (!cond(kind, target) && n < budget) begin
      cyc(1'b0, 8'h00);
      n++;
    end
    if (!cond(kind, target)) begin
      total++; bad++;
      $display("FAIL timeout %s actual=expired required=condition", name);
    end
  endtask

  task automatic clr();
    s_on_cnt = 0; s_hold_cnt = 0; e_on_cnt = 0;
  endtask

  initial begin
    repeat (3) cyc(1'b0, 8'h00);
    rst_n = 1'b1;
    check("reset_outputs", {shell_en, shell_ls, explo_en, explo_ls, shell_busy, explo_busy}, 0);

    // Single shell shot: 250 ON ticks then 16 hold-off ticks.
    clr();
    cyc(1'b1, 8'h08);
    check("shell_latency", shell_en, 1);
    run_until(2, 0, 2000, "shell_idle");
    check("shell_on_ticks", s_on_cnt, 250);
    check("shell_hold_ticks", s_hold_cnt, 16);
    check("explo_quiet", e_on_cnt, 0);

    // Repeated 1 does not retrigger.
    clr();
    cyc(1'b1, 8'h04);
    run_until(1, 100, 600, "explo_100");
    cyc(1'b1, 8'h04);
    run_until(3, 0, 2000, "explo_idle_a");
    check("explo_no_retrig", e_on_cnt, 250);
    check("explo_ls_soft", explo_ls, 0);

    // Re-armed request at tick 100 reloads: 350 ticks total.
    clr();
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h04);
    run_until(1, 100, 600, "explo_100b");
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h05);
    run_until(3, 0, 2000, "explo_idle_b");
    check("explo_retrig_ticks", e_on_cnt, 350);
    check("explo_ls_loud", explo_ls, 1);

    // Explosion preempts an ON shell.
    cyc(1'b1, 8'h00);
    clr();
    cyc(1'b1, 8'h08);
    run_until(0, 100, 600, "shell_100");
    cyc(1'b1, 8'h00);
    clr();
    cyc(1'b1, 8'h04);
    check("preempt_shell_en", shell_en, 0);
    check("preempt_shell_busy", shell_busy, 1);
    check("preempt_explo_en", explo_en, 1);
    run_until(3, 0, 2000, "explo_idle_c");
    check("preempt_explo_ticks", e_on_cnt, 250);
    check("preempt_hold_ticks", s_hold_cnt, 16);

    // Requests dropped during hold-off, accepted after IDLE.
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h08);
    run_until(4, 0, 2000, "shell_hold");
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h0A);
    check("hold_drop_en", shell_en, 0);
    check("hold_drop_ls", shell_ls, 0);
    run_until(2, 0, 200, "shell_idle_d");
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h0A);
    check("idle_accept_en", shell_en, 1);
    check("idle_accept_ls", shell_ls, 1);

    // Mid-shot sound gate and reset.
    repeat (10) cyc(1'b0, 8'h00);
    se = 1'b0;
    cyc(1'b0, 8'h00);
    se = 1'b1;
    check("gate_off", {shell_en, shell_busy, explo_en, explo_busy}, 0);
    check("gate_ls_kept", shell_ls, 1);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h08);
    repeat (10) cyc(1'b0, 8'h00);
    rst_n = 1'b0;
    cyc(1'b0, 8'h00);
    rst_n = 1'b1;
    check("midshot_reset", {shell_en, shell_ls, explo_en, explo_ls, shell_busy, explo_busy}, 0);
    cyc(1'b1, 8'h0C);
    check("both_req_explo", explo_en, 1);
    check("both_req_shell", shell_en, 0);

    // Randomized traffic against the model.
    tick_mode = 1;
    for (int i = 0; i < 15000; i++) begin
      se    = ($urandom_range(0, 199) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      cyc($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
    end
    rst_n = 1'b1; se = 1'b1;
    cyc(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noise_event_sequencer.md
Name: noise_event_sequencer

Overview:
- Sequences the shell/explosion noise source from the CPU sound latch.
- Turns CPU request bits into timed shell_en/explo_en windows.
- Latches the loud/soft selects and applies a hold-off after each shot so the source's decay finishes undisturbed.
- Arbitrates explosion over shell. Sits between the CPU write decoder and the noise source; all timing is counted in clk_12KHz_en ticks.

Parameters:
- CNT_W, 12, width of per-channel tick counters.
- SHELL_ON_TICKS, 250, 12 kHz ticks shell_en stays high per shot (0 is treated as 1).
- EXPLO_ON_TICKS, 250, 12 kHz ticks explo_en stays high per shot (0 is treated as 1).
- HOLDOFF_TICKS, 16, 12 kHz ticks after ON during which new requests on that channel are dropped.
- EXPLO_PREEMPT, 1, when 1 an accepted explosion request forces an ON shell channel into HOLDOFF.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- clk_12KHz_en  in  1  one-clk tick enable, 12 kHz.
- sound_enable  in  1  global sound gate.
- cpu_wr  in  1  one-clk write strobe to sound latch.
- cpu_data  in  8  latch data: bit0 explo_ls, bit1 shell_ls, bit2 explo_req, bit3 shell_req; bits 7:4 ignored.
- shell_en  out  1  shell noise enable.
- shell_ls  out  1  shell loud/soft select.
- explo_en  out  1  explosion noise enable.
- explo_ls  out  1  explosion loud/soft select.
- shell_busy  out  1  shell channel not IDLE.
- explo_busy  out  1  explosion channel not IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs 0, both FSMs IDLE, counters 0.
  - Stored previous request bits 0.
  - Reset mid-shot aborts immediately; no hold-off follows.
- Request detection:
  - On cpu_wr, a request fires for bit2/bit3 if it is 1 now and was 0 in the previous write.
  - Previous bits update on every cpu_wr.
  - Repeated writes of 1 do not retrigger; writing 0 re-arms the bit.
- Per-channel FSM, states IDLE, ON, HOLDOFF; counter decrements only on clk_12KHz_en.
- IDLE:
  - A request is accepted: next clk state=ON, en=1, counter loaded with ON_TICKS.
  - ls is latched from its cpu_data bit on that same write.
- ON:
  - Tick with counter==1: next state HOLDOFF, en=0, counter loaded with HOLDOFF_TICKS, or IDLE directly if HOLDOFF_TICKS=0.
  - Otherwise the tick decrements the counter.
  - A request in ON retriggers: counter reloaded with ON_TICKS, ls re-latched, en stays 1.
  - en is high for exactly ON_TICKS ticks after the last accepted request; partial first tick counts as up to one tick of jitter.
- HOLDOFF:
  - en=0; requests are dropped, not queued.
  - Tick with counter==1 goes to IDLE; otherwise decrement.
  - ls holds its latched value through HOLDOFF and IDLE; it changes only on acceptance.
- Preemption (EXPLO_PREEMPT=1):
  - Explosion request accepted while shell is ON: shell goes to HOLDOFF on the same clk (shell_en=0 next cycle).
  - Explosion and shell requests in the same write: explosion accepted, shell dropped.
  - With EXPLO_PREEMPT=0 the channels are fully independent; simultaneous requests are both accepted.
- sound_enable=0:
  - Both FSMs forced to IDLE synchronously; en=0, busy=0, counters cleared.
  - Requests are ignored, but previous-bit tracking still updates on cpu_wr.
  - ls outputs retain their values.
- Tick and request on the same clk in ON: the request wins (reload); the tick is not also applied.
- Outputs are registered; latency from cpu_wr to en=1 is 1 clk.

Test Plan:
- Reset then cpu_wr data=0x08, ticks every 4 clk -> shell_en=1 next clk for 250 ticks (1000 clk ±4), shell_busy stays 1 for 16 further ticks, then 0; explo_en stays 0.
- Write 0x04, then 0x04 again after 100 ticks -> no retrigger, explo_en low after 250 ticks. Repeat with write 0x00 then 0x05 at tick 100 -> counter reloads, explo_en high 350 ticks total, explo_ls=1.
- Write 0x08; 100 ticks later write 0x04 (EXPLO_PREEMPT=1) -> shell_en drops next clk and shell_busy stays 1 for 16 ticks; explo_en high for 250 ticks.
- During shell HOLDOFF, write 0x00 then 0x0A -> request dropped, shell_en stays 0, shell_ls unchanged; the same write after IDLE -> accepted, shell_ls=1.
- Mid-shot sound_enable=0 for one clk -> both en/busy 0 next clk. Mid-shot rst_n=0 -> all outputs 0; subsequent write 0x0C -> only explo_en=1 (preempt rule).
